// File: rtl/mips_seq_alu.sv
// mips_seq_alu: registered MIPS ALU with iterative multiply and divide.
// Single-cycle ops finish in one clock; MUL*/DIV* take WIDTH step cycles.
module mips_seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             less,
   output logic             overflow,
   output logic             div_zero,
   output logic             illegal
);
   localparam logic [4:0] OP_ADDU  = 5'b00000, OP_SUBU  = 5'b00001;
   localparam logic [4:0] OP_CLZ   = 5'b00010, OP_CLO   = 5'b00011;
   localparam logic [4:0] OP_AND   = 5'b00100, OP_SLT   = 5'b00101;
   localparam logic [4:0] OP_OR    = 5'b00110, OP_SLTU  = 5'b00111;
   localparam logic [4:0] OP_NOR   = 5'b01000, OP_XOR   = 5'b01001;
   localparam logic [4:0] OP_SEB   = 5'b01010, OP_SEH   = 5'b01011;
   localparam logic [4:0] OP_ADD   = 5'b01110, OP_SUB   = 5'b01111;
   localparam logic [4:0] OP_MULT  = 5'b10000, OP_MULTU = 5'b10001;
   localparam logic [4:0] OP_DIV   = 5'b10010, OP_DIVU  = 5'b10011;

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, a_q, a_d;
   logic neg_q, neg_d, rneg_q, rneg_d, dzop_q, dzop_d, dovf_q, dovf_d;
   logic [WIDTH-1:0] res_q, res_d, rhi_q, rhi_d;
   logic zero_q, zero_d, less_q, less_d, ovf_q, ovf_d;
   logic dz_q, dz_d, ill_q, ill_d;

   logic is_mul, is_div, is_sub, sgn_op, a_neg, b_neg, add_ovf;
   logic [WIDTH-1:0] a_mag, b_mag, b_add, sc_res;
   logic [WIDTH:0] sum;
   logic sc_less, sc_ovf, sc_ill;
   logic [CNT_W-1:0] lead;

   assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
   assign a_neg  = sgn_op & data_a[WIDTH-1];
   assign b_neg  = sgn_op & data_b[WIDTH-1];
   assign a_mag  = a_neg ? -data_a : data_a;
   assign b_mag  = b_neg ? -data_b : data_b;
   assign is_sub = (op == OP_SUBU) || (op == OP_SUB) ||
                   (op == OP_SLT) || (op == OP_SLTU);
   assign b_add  = is_sub ? ~data_b : data_b;
   assign sum    = {1'b0, data_a} + {1'b0, b_add} +
                   {{WIDTH{1'b0}}, is_sub};
   assign add_ovf = (data_a[WIDTH-1] == b_add[WIDTH-1]) &&
                    (sum[WIDTH-1] != data_a[WIDTH-1]);

   // CLO counts leading ones, so the scan stops at the first zero
   always_comb begin
      lead = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++)
         if (data_a[i] != (op == OP_CLO))
            lead = CNT_W'(WIDTH - 1 - i);
   end

   always_comb begin
      sc_res  = '0;
      sc_less = 1'b0;
      sc_ovf  = 1'b0;
      sc_ill  = 1'b0;
      case (op)
         OP_ADDU, OP_SUBU: sc_res = sum[WIDTH-1:0];
         OP_ADD, OP_SUB: begin
            sc_res = sum[WIDTH-1:0];
            sc_ovf = add_ovf;
         end
         OP_CLZ, OP_CLO: sc_res = WIDTH'(lead);
         OP_AND: sc_res = data_a & data_b;
         OP_OR:  sc_res = data_a | data_b;
         OP_NOR: sc_res = ~(data_a | data_b);
         OP_XOR: sc_res = data_a ^ data_b;
         OP_SLT: begin
            sc_less = add_ovf ^ sum[WIDTH-1];
            sc_res  = {{(WIDTH-1){1'b0}}, sc_less};
         end
         OP_SLTU: begin
            sc_less = ~sum[WIDTH];
            sc_res  = {{(WIDTH-1){1'b0}}, sc_less};
         end
         OP_SEB: sc_res = {{(WIDTH-8){data_b[7]}}, data_b[7:0]};
         OP_SEH: sc_res = {{(WIDTH-16){data_b[15]}}, data_b[15:0]};
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: ;
         default: sc_ill = 1'b1;
      endcase
   end

   logic [WIDTH:0] msum, dsh, ddiff;
   logic dge;
   logic [WIDTH-1:0] mhi, mlo, dhi, dlo, qf, rf;
   logic [2*WIDTH-1:0] prod, pf;

   assign msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
   assign mhi   = msum[WIDTH:1];
   assign mlo   = {msum[0], lo_q[WIDTH-1:1]};
   assign dsh   = {hi_q, lo_q[WIDTH-1]};
   assign ddiff = dsh - {1'b0, m_q};
   assign dge   = ~ddiff[WIDTH];
   assign dhi   = dge ? ddiff[WIDTH-1:0] : dsh[WIDTH-1:0];
   assign dlo   = {lo_q[WIDTH-2:0], dge};
   assign prod  = {mhi, mlo};
   assign pf    = neg_q ? -prod : prod;
   assign qf    = neg_q ? -dlo : dlo;
   assign rf    = rneg_q ? -dhi : dhi;

   always_comb begin
      st_d = st_q;  cnt_d = cnt_q;
      m_d = m_q;    hi_d = hi_q;   lo_d = lo_q;   a_d = a_q;
      neg_d = neg_q;   rneg_d = rneg_q;
      dzop_d = dzop_q; dovf_d = dovf_q;
      res_d = res_q;   rhi_d = rhi_q;  zero_d = zero_q;
      less_d = less_q; ovf_d = ovf_q;  dz_d = dz_q;  ill_d = ill_q;
      unique case (st_q)
         S_IDLE: if (in_valid) begin
            cnt_d  = '0;
            hi_d   = '0;
            a_d    = data_a;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            dzop_d = (data_b == '0);
            dovf_d = (op == OP_DIV) && (data_a == MIN_NEG) && (&data_b);
            if (is_mul) begin
               st_d = S_MUL;
               m_d  = a_mag;
               lo_d = b_mag;
            end else if (is_div) begin
               st_d = S_DIV;
               m_d  = b_mag;
               lo_d = a_mag;
            end else begin
               st_d   = S_DONE;
               res_d  = sc_res;
               rhi_d  = '0;
               zero_d = (sc_res == '0);
               less_d = sc_less;
               ovf_d  = sc_ovf;
               dz_d   = 1'b0;
               ill_d  = sc_ill;
            end
         end
         S_MUL: begin
            hi_d  = mhi;
            lo_d  = mlo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               st_d   = S_DONE;
               res_d  = pf[WIDTH-1:0];
               rhi_d  = pf[2*WIDTH-1:WIDTH];
               zero_d = (pf[WIDTH-1:0] == '0);
               less_d = 1'b0; ovf_d = 1'b0; dz_d = 1'b0; ill_d = 1'b0;
            end
         end
         S_DIV: begin
            hi_d  = dhi;
            lo_d  = dlo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               st_d   = S_DONE;
               res_d  = dzop_q ? '1 : qf;
               rhi_d  = dzop_q ? a_q : rf;
               zero_d = dzop_q ? 1'b0 : (qf == '0);
               less_d = 1'b0;
               ovf_d  = dovf_q;
               dz_d   = dzop_q;
               ill_d  = 1'b0;
            end
         end
         S_DONE: if (out_ready) begin
            st_d = S_IDLE;
            res_d = '0; rhi_d = '0; zero_d = 1'b0; less_d = 1'b0;
            ovf_d = 1'b0; dz_d = 1'b0; ill_d = 1'b0;
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= S_IDLE;  cnt_q <= '0;
         m_q <= '0; hi_q <= '0; lo_q <= '0; a_q <= '0;
         neg_q <= 1'b0; rneg_q <= 1'b0; dzop_q <= 1'b0; dovf_q <= 1'b0;
         res_q <= '0; rhi_q <= '0; zero_q <= 1'b0; less_q <= 1'b0;
         ovf_q <= 1'b0; dz_q <= 1'b0; ill_q <= 1'b0;
      end else begin
         st_q <= st_d;  cnt_q <= cnt_d;
         m_q <= m_d; hi_q <= hi_d; lo_q <= lo_d; a_q <= a_d;
         neg_q <= neg_d; rneg_q <= rneg_d; dzop_q <= dzop_d; dovf_q <= dovf_d;
         res_q <= res_d; rhi_q <= rhi_d; zero_q <= zero_d; less_q <= less_d;
         ovf_q <= ovf_d; dz_q <= dz_d; ill_q <= ill_d;
      end
   end

   assign in_ready  = (st_q == S_IDLE) && !rst;
   assign out_valid = (st_q == S_DONE);
   assign result    = res_q;
   assign result_hi = rhi_q;
   assign zero      = zero_q;
   assign less      = less_q;
   assign overflow  = ovf_q;
   assign div_zero  = dz_q;
   assign illegal   = ill_q;
endmodule

// File: doc/mips_seq_alu.md
Name: mips_seq_alu

Overview:
- Parametrised, registered successor of the single-cycle 32-bit MIPS ALU.
- Keeps the existing operations: add/sub, CLZ/CLO, logic, SLT/SLTU, SEB/SEH.
- Adds iterative multiply and divide (MULT/MULTU/DIV/DIVU) with a valid/ready handshake on both sides.
- Sits between the register-read stage and writeback; the control unit stalls issue while in_ready is low.

Parameters:
- WIDTH, 32, datapath width in bits; must be at least 16 and a power of two.
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op present
- in_ready  output  1  block can accept an operation
- op  input  5  operation code (table below)
- data_a  input  WIDTH  operand A (rs)
- data_b  input  WIDTH  operand B (rt/imm)
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  main result: LO for mul, quotient for div
- result_hi  output  WIDTH  mul high half or div remainder; 0 for other ops
- zero  output  1  result == 0
- less  output  1  SLT/SLTU compare outcome; 0 for other ops
- overflow  output  1  signed ADD/SUB overflow, or DIV most-negative/-1
- div_zero  output  1  DIV/DIVU with data_b == 0
- illegal  output  1  unassigned op code

Behaviour:
- Op codes:
  - 00000 ADDU, 00001 SUBU, 00010 CLZ, 00011 CLO
  - 00100 AND, 00101 SLT, 00110 OR, 00111 SLTU
  - 01000 NOR, 01001 XOR, 01010 SEB, 01011 SEH
  - 01110 ADD, 01111 SUB
  - 10000 MULT, 10001 MULTU, 10010 DIV, 10011 DIVU
  - All other codes are illegal.
- Reset:
  - State goes to IDLE; in_ready=0 during the reset cycle and 1 after it.
  - out_valid=0; result, result_hi and all flags are 0.
  - Reset mid-operation aborts the operation; no result is produced.
- State machine:
  - IDLE: in_ready=1. An accept occurs when in_valid&&in_ready; op and operands are latched.
  - From IDLE on accept: single-cycle ops go to DONE. MUL* goes to MUL and DIV* goes to DIV, each with counter=0.
  - MUL/DIV: one shift-add or restoring-subtract step per cycle. Exit to DONE when counter==WIDTH-1, i.e. WIDTH cycles in the state.
  - DONE: out_valid=1, all outputs stable. When out_ready=1, go to IDLE. While out_ready=0, hold.
  - Back-to-back: DONE→IDLE takes 1 cycle; a new accept is possible in the cycle after the handshake.
- Latency from accept to out_valid: single-cycle ops 1 clk; MUL/DIV ops WIDTH+1 clk.
- in_valid outside IDLE is ignored; the upstream stage holds its operands.
- Arithmetic, all modulo 2^WIDTH:
  - SUB/SUBU compute a+~b+1.
  - ADD/SUB overflow: the operand signs as applied to the adder (a and b, or a and ~b) agree, and the sign of the sum differs from them.
  - SLT uses the signed compare (overflow^sign); SLTU uses the borrow of a-b. Result is zero-extended 1 or 0, and less mirrors it.
  - CLZ counts leading zeros of data_a, range 0..WIDTH (all-zero input gives WIDTH). CLO counts leading ones the same way.
  - NOR returns ~(a|b).
  - SEB sign-extends b[7:0]; SEH sign-extends b[15:0].
  - MULT/MULTU produce a 2·WIDTH product as {result_hi,result}. Signed multiply: multiply magnitudes, negate the product if the operand signs differ.
  - DIV/DIVU: quotient in result, remainder in result_hi, truncating toward zero; remainder takes the sign of the dividend.
- Divide corner cases:
  - Divisor 0: result=all ones, result_hi=data_a, div_zero=1. Still takes full latency.
  - Signed most-negative/-1: result=most-negative, result_hi=0, overflow=1.
- Flags:
  - zero is evaluated on result only.
  - Flags not applicable to the completed op are 0.
  - Flags are registered alongside result and valid only while out_valid=1.
- Illegal op: 1-cycle latency, result=0, result_hi=0, illegal=1, zero=1.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1 -> 1 clk later out_valid, result=0x80000000, overflow=1; same operands with ADDU -> overflow=0.
- SLTU a=0x00000001 b=0xFFFFFFFF -> result=1, less=1; SLT same operands -> result=0, less=0; CLZ a=0 -> result=32; CLO a=0xF0000000 -> 4.
- MULT a=0xFFFFFFFE(-2) b=3 -> out_valid exactly 33 clk after accept, {hi,lo}=0xFFFFFFFF_FFFFFFFA; MULTU same -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=-7 b=2 -> result=0xFFFFFFFD(-3), result_hi=0xFFFFFFFF(-1); DIVU a=100 b=0 -> result=0xFFFFFFFF, result_hi=100, div_zero=1; DIV 0x80000000/-1 -> overflow=1, result=0x80000000.
- Handshake: hold out_ready=0 for 5 clk after DONE -> outputs stable, in_ready=0, second in_valid ignored; raise out_ready -> next cycle in_ready=1, then the new op is accepted.
- Assert rst 10 clk into a DIV -> next cycle out_valid=0, all outputs 0; after reset release in_ready=1, and the following ADDU 2+3 returns 5 with no stale result.
